// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART command link
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} rx_state_t;
    localparam int BAUD_DIV_DEF = 2604;
    localparam int UART_DATA_W = 8;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for an asynchronous input with selectable reset value
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;
    // capture into the metastability flop, then re-register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= {RST_VAL, RST_VAL};
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/uart_cmd_rx.sv
// uart_cmd_rx: 8N1 UART receiver with rdy/clr_rdy handshake, framing and overrun reporting
module uart_cmd_rx
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   RX,
    input  logic                   clr_rdy,
    output logic [UART_DATA_W-1:0] rx_data,
    output logic                   rdy,
    output logic                   frm_err,
    output logic                   ovr_err
);
    localparam int CW = $clog2(BAUD_DIV);
    localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);

    rx_state_t state, state_n;
    logic rx_s;
    logic [CW-1:0] cnt;
    logic [3:0] bit_cnt;
    logic [UART_DATA_W:0] shreg;
    logic tick, load_half, load_full, shift, clr_bits, done, ferr;

    sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(RX), .q(rx_s));

    assign tick = (cnt == '0);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state and datapath strobes; the start bit is shifted in too so a
    // complete frame is checked for a low start and a high stop bit
    always_comb begin
        state_n   = state;
        load_half = 1'b0;
        load_full = 1'b0;
        shift     = 1'b0;
        clr_bits  = 1'b0;
        done      = 1'b0;
        ferr      = 1'b0;
        case (state)
            IDLE: if (!rx_s) begin
                state_n   = START;
                load_half = 1'b1;
            end
            START: if (tick) begin
                state_n   = rx_s ? IDLE : DATA;
                load_full = !rx_s;
                clr_bits  = !rx_s;
                shift     = !rx_s;
            end
            DATA: if (tick) begin
                shift     = 1'b1;
                load_full = 1'b1;
                state_n   = (bit_cnt == 4'd7) ? STOP : DATA;
            end
            STOP: if (tick) begin
                done    = rx_s && !shreg[0];
                ferr    = !done;
                state_n = done ? IDLE : BRK;
            end
            BRK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // baud counter, bit counter and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            cnt     <= load_half ? HALF : load_full ? FULL : tick ? cnt : cnt - 1'b1;
            bit_cnt <= clr_bits ? 4'd0 : shift ? bit_cnt + 4'd1 : bit_cnt;
            shreg   <= shift ? {rx_s, shreg[UART_DATA_W:1]} : shreg;
        end
    end

    // consumer-facing outputs; a completing byte outranks a same-cycle clr_rdy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
            ovr_err <= 1'b0;
        end else begin
            rx_data <= done ? shreg[UART_DATA_W:1] : rx_data;
            rdy     <= done | (rdy & ~clr_rdy);
            frm_err <= ferr;
            ovr_err <= clr_rdy ? 1'b0 : (ovr_err | (done & rdy));
        end
    end
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb_uart_cmd_rx: randomized self-checking bench for uart_cmd_rx against a frame-level model
module tb_uart_cmd_rx;
    localparam int BD = 32;
    localparam int LAT = 19 * BD / 2 + 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx = 1'b1;
    logic clr_rdy = 1'b0;
    logic [7:0] rx_data;
    logic rdy, frm_err, ovr_err;

    int checks = 0;
    int errors = 0;
    int frm_cnt = 0;
    logic [7:0] exp_data = 8'h00;
    logic exp_rdy = 1'b0;
    logic exp_ovr = 1'b0;
    int exp_frm = 0;

    uart_cmd_rx #(.BAUD_DIV(BD)) dut (
        .clk(clk), .rst(rst), .RX(rx), .clr_rdy(clr_rdy),
        .rx_data(rx_data), .rdy(rdy), .frm_err(frm_err), .ovr_err(ovr_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frm_err === 1'b1) frm_cnt <= frm_cnt + 1;

    initial begin
        #800000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_data"}, 32'(rx_data), 32'(exp_data));
        check({tag, "_rdy"}, 32'(rdy), 32'(exp_rdy));
        check({tag, "_ovr"}, 32'(ovr_err), 32'(exp_ovr));
        check({tag, "_frm"}, 32'(frm_cnt), 32'(exp_frm));
    endtask

    task automatic bits(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        bits(BD);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            bits(BD);
        end
        if (stop_ok) begin
            rx = 1'b1;
            bits(BD);
        end else begin
            rx = 1'b0;
            bits(3 * BD);
            rx = 1'b1;
            bits(BD);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit stop_ok);
        send_frame(b, stop_ok);
        if (stop_ok) begin
            exp_ovr = exp_ovr | exp_rdy;
            exp_rdy = 1'b1;
            exp_data = b;
        end else exp_frm++;
    endtask

    task automatic pulse_clr();
        clr_rdy = 1'b1;
        bits(1);
        clr_rdy = 1'b0;
        exp_rdy = 1'b0;
        exp_ovr = 1'b0;
    endtask

    initial begin
        int n;
        bits(3);
        check_all("reset");
        rst = 1'b0;
        bits(2);

        n = 0;
        fork
            send_frame(8'h47, 1'b1);
            begin
                while (rdy !== 1'b1 && n < 20 * BD) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
            end
        join
        exp_rdy = 1'b1;
        exp_data = 8'h47;
        check("latency", 32'(n >= 19 * BD / 2 - 4 && n <= 19 * BD / 2 + 4), 32'd1);
        check_all("first");
        pulse_clr();
        check_all("first_clr");

        rx = 1'b0;
        bits(BD / 4);
        rx = 1'b1;
        bits(2 * BD);
        check_all("glitch");
        frame(8'h53, 1'b1);
        check_all("after_glitch");
        pulse_clr();
        exp_data = 8'h53;

        frame(8'h55, 1'b0);
        check_all("bad_stop");
        frame(8'hA5, 1'b1);
        check_all("after_break");
        pulse_clr();

        frame(8'h11, 1'b1);
        frame(8'h22, 1'b1);
        check_all("overrun");
        pulse_clr();
        check_all("overrun_clr");

        frame(8'h66, 1'b1);
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (LAT - 1) @(posedge clk);
                #1 clr_rdy = 1'b1;
                @(posedge clk);
                #1 clr_rdy = 1'b0;
            end
        join
        exp_rdy = 1'b1;
        exp_ovr = 1'b0;
        exp_data = 8'h77;
        check_all("clr_same_cycle");

        fork
            send_frame(8'hF0, 1'b1);
            begin
                repeat (5 * BD + BD / 2) @(posedge clk);
                #1 rst = 1'b1;
                bits(10);
                exp_data = 8'h00;
                exp_rdy = 1'b0;
                exp_ovr = 1'b0;
                check_all("mid_reset");
                rst = 1'b0;
            end
        join
        frame(8'h3C, 1'b1);
        check_all("after_reset");
        pulse_clr();

        for (int k = 0; k < 24; k++) begin
            logic [7:0] b;
            bit ok;
            b = 8'($urandom);
            ok = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 2) == 0) pulse_clr();
            if ($urandom_range(0, 1) == 1) bits($urandom_range(1, BD));
            frame(b, ok);
            check_all("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
